// File: rtl/tweak_fetch_if.sv
// Fetch-stage bundle: ROM request/response, redirect/halt control, decoder handshake.
// Latency: none (wires only).
// Backpressure: ins_ready from the decoder; the ROM side has no backpressure.
interface tweak_fetch_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 32
);
    logic                  rom_read_ena;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [WORD_WIDTH-1:0] rom_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  halt;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [WORD_WIDTH-1:0] ins_opcode;
    logic [ADDR_WIDTH-1:0] ins_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc;

    // Fetch stage side
    modport master (
        output rom_read_ena, rom_addr, ins_valid, ins_opcode, ins_pc, fetch_pc,
        input  rom_data, redirect_valid, redirect_addr, halt, ins_ready
    );

    // ROM / decoder / control side
    modport slave (
        input  rom_read_ena, rom_addr, ins_valid, ins_opcode, ins_pc, fetch_pc,
        output rom_data, redirect_valid, redirect_addr, halt, ins_ready
    );
endinterface

// File: rtl/tweak_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle sync ROM, queues {word, pc} for the decoder.
// Latency: request in cycle N -> word at the queue head (ins_valid=1) in cycle N+2.
// Backpressure: credit rule count+inflight<DEPTH throttles ROM reads; head held while ins_ready=0.
module tweak_fetch #(
    parameter int          ADDR_WIDTH = 4,
    parameter int          WORD_WIDTH = 32,
    parameter int          DEPTH      = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    tweak_fetch_if.master     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Registered state
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] tag_pc_q,   tag_pc_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [WORD_WIDTH-1:0] op_mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] op_mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d [DEPTH];

    // Combinational control
    logic             issue;
    logic             flush;
    logic             push;
    logic             pop;
    logic             head_vld;
    logic [CNT_W:0]   occ;

    // Issue/credit decision and the externally visible outputs
    always_comb begin
        occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        // Pops are deliberately not credited in the same cycle, so occupancy
        // can never exceed DEPTH once the in-flight word lands.
        issue    = !RESET && !bus.halt && !bus.redirect_valid
                   && (occ < (CNT_W+1)'(DEPTH));
        flush    = bus.redirect_valid;
        head_vld = (count_q != '0);
        push     = inflight_q && !flush;
        pop      = head_vld && bus.ins_ready && !flush;

        bus.rom_read_ena = issue;
        bus.rom_addr     = fetch_pc_q;
        bus.fetch_pc     = fetch_pc_q;
        bus.ins_valid    = head_vld;
        bus.ins_opcode   = op_mem_q[rd_ptr_q];
        bus.ins_pc       = pc_mem_q[rd_ptr_q];
    end

    // Next-state: PC advance/redirect, in-flight tag, queue push/pop/flush
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        op_mem_d   = op_mem_q;
        pc_mem_d   = pc_mem_q;

        if (flush) begin
            fetch_pc_d = bus.redirect_addr;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
        end

        if (issue) begin
            tag_pc_d = fetch_pc_q;
        end

        if (flush) begin
            // Drop everything queued plus the word returning this cycle.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                op_mem_d[wr_ptr_q] = bus.rom_data;
                pc_mem_d[wr_ptr_q] = tag_pc_q;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset dominates and also discards any returning ROM word
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            op_mem_q   <= '{default: '0};
            pc_mem_q   <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            op_mem_q   <= op_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end
endmodule

// File: tb/tb_tweak_fetch.sv
// Directed bench for tweak_fetch: streaming, backpressure, redirect, PC wrap, halt, mid-run reset.
// ROM model returns 32'h1000_0000 + address one cycle after the request.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after posedge.
module tb_tweak_fetch;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    logic [3:0] exp_pc;

    tweak_fetch_if #(.ADDR_WIDTH(4), .WORD_WIDTH(32)) bus ();

    tweak_fetch #(
        .ADDR_WIDTH (4),
        .WORD_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (0)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous instruction ROM
    always @(posedge CLK) begin
        bus.rom_data <= 32'h1000_0000 + 32'(bus.rom_addr);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Head must be the next expected sequential word
    task automatic beat(input string tag);
        check({tag, "_vld"}, 32'(bus.ins_valid), 32'd1);
        check({tag, "_pc"},  32'(bus.ins_pc), 32'(exp_pc));
        check({tag, "_op"},  bus.ins_opcode, 32'h1000_0000 + 32'(exp_pc));
        exp_pc = exp_pc + 4'd1;
    endtask

    // Consume n words in order within a cycle budget
    task automatic run_stream(input int n, input int budget, input string tag);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < budget) begin
            tick();
            #1;
            if (bus.ins_valid && bus.ins_ready) begin
                beat(tag);
                seen = seen + 1;
            end
            cyc = cyc + 1;
        end
        check({tag, "_count"}, 32'(seen), 32'(n));
    endtask

    // Two reset cycles; returns in the first cycle with RESET low
    task automatic do_reset();
        RESET              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.halt           = 1'b0;
        tick();
        tick();
        RESET  = 1'b0;
        exp_pc = 4'd0;
    endtask

    initial begin
        logic [3:0] frozen;
        int         halt_beats;
        checks             = 0;
        errors             = 0;
        exp_pc             = 4'd0;
        frozen             = 4'd0;
        halt_beats         = 0;
        RESET              = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 4'd0;
        bus.ins_ready      = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_vld",  32'(bus.ins_valid), 32'd0);
        check("rst_ena",  32'(bus.rom_read_ena), 32'd0);
        check("rst_op",   bus.ins_opcode, 32'd0);
        check("rst_pc",   32'(bus.ins_pc), 32'd0);
        check("rst_fpc",  32'(bus.fetch_pc), 32'd0);

        // Plain streaming from RESET_PC
        RESET         = 1'b0;
        bus.ins_ready = 1'b1;
        #1;
        check("c0_ena",  32'(bus.rom_read_ena), 32'd1);
        check("c0_addr", 32'(bus.rom_addr), 32'd0);
        check("c0_vld",  32'(bus.ins_valid), 32'd0);
        tick(); #1;
        check("c1_vld",  32'(bus.ins_valid), 32'd0);
        tick(); #1;
        beat("first");
        run_stream(6, 6, "stream");

        // Backpressure: decoder stalls for 10 cycles from the first valid word
        do_reset();
        bus.ins_ready = 1'b0;
        tick();
        for (int k = 2; k <= 11; k++) begin
            tick(); #1;
            check("hold_vld", 32'(bus.ins_valid), 32'd1);
            check("hold_pc",  32'(bus.ins_pc), 32'd0);
            check("hold_ena", 32'(bus.rom_read_ena), (k <= 3) ? 32'd1 : 32'd0);
        end
        check("hold_fpc", 32'(bus.fetch_pc), 32'd4);
        tick();
        bus.ins_ready = 1'b1;
        #1;
        beat("release");
        run_stream(7, 7, "release");

        // Redirect with pcs 2..4 queued and pc 5 in flight
        do_reset();
        bus.ins_ready = 1'b1;
        tick();
        tick(); #1; beat("pre_rd");
        tick(); #1; beat("pre_rd");
        tick();
        bus.ins_ready = 1'b0;
        #1;
        check("q_head", 32'(bus.ins_pc), 32'd2);
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 4'hA;
        #1;
        check("rd_ena",   32'(bus.rom_read_ena), 32'd0);
        check("rd_head",  32'(bus.ins_pc), 32'd2);
        tick();
        bus.redirect_valid = 1'b0;
        bus.ins_ready      = 1'b1;
        #1;
        check("rd1_vld",  32'(bus.ins_valid), 32'd0);
        check("rd1_ena",  32'(bus.rom_read_ena), 32'd1);
        check("rd1_addr", 32'(bus.rom_addr), 32'hA);
        tick(); #1;
        check("rd2_vld",  32'(bus.ins_valid), 32'd0);
        tick(); #1;
        exp_pc = 4'hA;
        beat("after_rd");
        tick(); #1;
        beat("after_rd");

        // Redirect in the same cycle the decoder accepts the head
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 4'h5;
        #1;
        check("rdpop_vld", 32'(bus.ins_valid), 32'd1);
        check("rdpop_pc",  32'(bus.ins_pc), 32'hC);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("rdpop1_vld",  32'(bus.ins_valid), 32'd0);
        check("rdpop1_addr", 32'(bus.rom_addr), 32'h5);
        tick(); #1;
        check("rdpop2_vld",  32'(bus.ins_valid), 32'd0);
        tick(); #1;
        exp_pc = 4'h5;
        beat("rdpop");
        run_stream(1, 1, "rdpop");

        // PC wrap from 4'hE
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 4'hE;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("wrap_fpc",  32'(bus.fetch_pc), 32'hE);
        check("wrap_addr", 32'(bus.rom_addr), 32'hE);
        tick();
        tick(); #1;
        exp_pc = 4'hE;
        beat("wrap");
        run_stream(3, 3, "wrap");

        // Halt for 5 cycles mid-stream
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.halt = 1'b1;
            #1;
            check("halt_ena", 32'(bus.rom_read_ena), 32'd0);
            if (i == 0) begin
                frozen = bus.fetch_pc;
            end else begin
                check("halt_fpc", 32'(bus.fetch_pc), 32'(frozen));
            end
            if (bus.ins_valid) begin
                beat("halt");
                halt_beats = halt_beats + 1;
            end
        end
        check("halt_drain", 32'(halt_beats), 32'd2);
        tick();
        bus.halt = 1'b0;
        #1;
        check("resume_ena",  32'(bus.rom_read_ena), 32'd1);
        check("resume_addr", 32'(bus.rom_addr), 32'(exp_pc));
        run_stream(4, 8, "resume");

        // One-cycle reset mid-stream
        tick();
        RESET = 1'b1;
        #1;
        check("mrst_ena", 32'(bus.rom_read_ena), 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        check("mrst1_vld",  32'(bus.ins_valid), 32'd0);
        check("mrst1_pc",   32'(bus.ins_pc), 32'd0);
        check("mrst1_fpc",  32'(bus.fetch_pc), 32'd0);
        check("mrst1_ena",  32'(bus.rom_read_ena), 32'd1);
        check("mrst1_addr", 32'(bus.rom_addr), 32'd0);
        tick(); #1;
        check("mrst2_vld",  32'(bus.ins_valid), 32'd0);
        tick(); #1;
        exp_pc = 4'd0;
        beat("mrst");
        run_stream(3, 3, "mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tweak_fetch.md
Name: tweak_fetch

Overview:
Instruction fetch stage that sits directly upstream of tweak_decoder in tweak_cpu. It owns the program counter and issues one read per cycle to a synchronous instruction ROM. It buffers returned words with their addresses in a small prefetch queue and presents them to the decoder through a valid/ready handshake. A redirect input supports jumps and branches; on redirect the block flushes queued and in-flight words and restarts at the new address.

Parameters:
ADDR_WIDTH, 4, width of PC and ROM address; PC wraps modulo 2^ADDR_WIDTH.
WORD_WIDTH, 32, instruction word width.
DEPTH, 4, prefetch queue entries; power of 2, minimum 4.
RESET_PC, 0, PC value loaded on reset.

Ports:
CLK  in  1  single clock; all state updates on posedge.
RESET  in  1  synchronous, active-high reset.
rom_read_ena  out  1  ROM read request this cycle.
rom_addr  out  ADDR_WIDTH  ROM address; meaningful only when rom_read_ena=1.
rom_data  in  WORD_WIDTH  ROM word; valid in the cycle after the request, 1-cycle fixed latency.
redirect_valid  in  1  single-cycle pulse requesting a PC change.
redirect_addr  in  ADDR_WIDTH  new PC; sampled when redirect_valid=1.
halt  in  1  level; while high, no new ROM requests are issued.
ins_valid  out  1  queue head is valid.
ins_ready  in  1  decoder accepts the head this cycle.
ins_opcode  out  WORD_WIDTH  head instruction word, feeds the decoder's OPCODE input.
ins_pc  out  ADDR_WIDTH  address of the head word.
fetch_pc  out  ADDR_WIDTH  next address to be requested.

Behaviour:
- Reset (RESET=1 at posedge):
  - fetch_pc=RESET_PC, queue empty (count=0), inflight=0.
  - ins_valid=0, rom_read_ena=0, ins_opcode=0, ins_pc=0.
  - Any in-flight ROM response is discarded, including RESET asserted mid-operation.
  - RESET has priority over every other input.
- Issue (combinational):
  - rom_read_ena = !RESET && !halt && !redirect_valid && (count + inflight < DEPTH).
  - rom_addr = fetch_pc.
  - On an issuing edge: fetch_pc <= fetch_pc+1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - inflight <= rom_read_ena, registered. The request address is held in a register tag_pc.
- Capture: at the edge where inflight=1 and no flush occurs, {rom_data, tag_pc} is pushed to the queue tail.
- Latency: request issued in cycle N; the word is in the queue and ins_valid=1 in cycle N+2.
- After reset release, the first request (rom_addr=RESET_PC) is in the first cycle with RESET low.
- Output:
  - ins_valid = (count!=0). ins_opcode and ins_pc come from the queue head, registered storage.
  - Pop on the edge where ins_valid && ins_ready.
  - ins_valid=0 with ins_ready=1 is a no-op.
  - While ins_valid=1 and ins_ready=0, the head is held stable.
- Simultaneous push and pop: both occur and count is unchanged.
- Overflow: impossible by credit rule, because count+inflight is bounded by DEPTH. Pop is not credited in the same cycle.
- Throughput: with ins_ready=1 continuously and halt=0, one instruction per cycle in steady state.
- Redirect (redirect_valid=1 at posedge, RESET=0):
  - Queue cleared, inflight response dropped, fetch_pc <= redirect_addr.
  - No request issues that cycle.
  - A pop in the same cycle is ignored, because flush dominates.
  - The first request to redirect_addr is in the next cycle; ins_valid is low for at least 2 cycles after the redirect edge.
- Halt: blocks new requests only.
  - An in-flight word is still captured and the queue keeps draining.
  - fetch_pc is frozen.
  - Deasserting halt resumes from fetch_pc.
- Redirect during halt: the flush and PC load still occur; fetching resumes when halt deasserts.
- Wrap-around: the queue pointers are log2(DEPTH) bits plus an explicit count; PC wrap is silent.

Test Plan:
- Reset, then stream with ins_ready=1, ROM[i]=32'h1000_0000+i: ins_valid first high 2 cycles after RESET falls; ins_pc=0,1,2,… one per cycle; ins_opcode matches ROM[ins_pc].
- ins_ready=0 for 10 cycles after the first valid: rom_read_ena drops once count+inflight=4. Head stays ins_pc=0 throughout. Release ins_ready: pcs 0..3 are delivered back-to-back and streaming continues with no gap beyond 1 cycle.
- Redirect to 4'hA while the queue holds pcs 2..4 and one read is in flight: pcs 2..4 are never delivered after the redirect edge. Next rom_addr=4'hA; next ins_pc is 4'hA, then 4'hB.
- Redirect with ins_valid=1 and ins_ready=1 in the same cycle: the head is not counted as consumed, and the next delivered ins_pc equals redirect_addr.
- fetch_pc=4'hE, stream: ins_pc sequence E,F,0,1 with correct words.
- Halt 5 cycles mid-stream, then assert RESET for 1 cycle mid-stream:
  - Halt: rom_read_ena=0 during halt, the in-flight word is delivered, and no pcs are skipped or duplicated on resume.
  - Reset: ins_valid=0 the cycle after, the in-flight word is discarded, and the stream restarts at RESET_PC.
